// File: rtl/dlfloat_operand_loader.sv
// rtl/dlfloat_operand_loader.sv - byte-stream to DLFloat16 operand-pair loader with FWFT FIFO
//
// Purpose: assembles (a, b) DLFloat16 operand pairs from a byte stream, queues
// them together with in-band accumulator-clear tokens in a first-word-fall-through
// FIFO, and presents the FIFO head to the MAC with a valid/ready handshake.
// Optional build macro: DLF_OPERAND_CHECK_EN flushes denormal operands to 0x0000
// at push time and reports it in err_status[2].
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_byte, in_valid, in_cmd        data/command byte input, qualified by in_valid
//   in_ready                         loader can take a byte (FIFO not full)
//   out_a, out_b, out_clr            FIFO head: operands and clear-token flag
//   out_valid, out_ready             FIFO head handshake
//   err_status                       sticky: [0] frame abort, [1] unknown cmd, [2] denormal flushed
//   fifo_count                       current number of queued entries

module dlfloat_operand_loader #(
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  in_byte,
    input  logic                        in_valid,
    input  logic                        in_cmd,
    output logic                        in_ready,
    output logic [15:0]                 out_a,
    output logic [15:0]                 out_b,
    output logic                        out_clr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [2:0]                  err_status,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    localparam logic [7:0] CMD_NOP     = 8'h00;
    localparam logic [7:0] CMD_CLR     = 8'h01;
    localparam logic [7:0] CMD_CLR_ERR = 8'h02;

    typedef enum logic [1:0] {
        A_HI = 2'd0,
        A_LO = 2'd1,
        B_HI = 2'd2,
        B_LO = 2'd3
    } asm_state_t;

    asm_state_t state_q, state_d;

    // first_q holds the first-arriving byte of the operand in progress; a_q holds
    // the completed operand a while b is being collected.
    logic [7:0]  first_q;
    logic [15:0] a_q;
    logic [2:0]  err_q, err_d;

    logic        byte_acc;
    logic        data_acc;
    logic        cmd_acc;
    logic        push;
    logic        pop;
    logic        push_clr;
    logic [15:0] push_a;
    logic [15:0] push_b;

    logic [32:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    // The state names describe position in the frame (first/second byte of each
    // operand); MSB_FIRST only decides which half of the word the first byte is.
    function automatic logic [15:0] join_bytes(input logic [7:0] first, input logic [7:0] second);
        if (MSB_FIRST != 0) begin
            return {first, second};
        end
        return {second, first};
    endfunction

`ifdef DLF_OPERAND_CHECK_EN
    function automatic logic is_denormal(input logic [15:0] v);
        return (v[14:9] == 6'd0) && (v[8:0] != 9'd0);
    endfunction
`endif

    // in_ready depends only on the registered occupancy, so a pop in the same
    // cycle never opens a slot early and a push while full cannot happen.
    assign in_ready  = (count != DEPTH);
    assign out_valid = (count != '0);
    assign byte_acc  = in_valid & in_ready;
    assign data_acc  = byte_acc & ~in_cmd;
    assign cmd_acc   = byte_acc & in_cmd;
    assign pop       = out_valid & out_ready;

    assign out_clr    = mem[rd_ptr][32];
    assign out_a      = mem[rd_ptr][31:16];
    assign out_b      = mem[rd_ptr][15:0];
    assign err_status = err_q;
    assign fifo_count = count;

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        push     = 1'b0;
        push_clr = 1'b0;
        push_a   = '0;
        push_b   = '0;

        if (cmd_acc) begin
            // A command mid-frame throws away the partial pair but still runs.
            if (state_q != A_HI) begin
                err_d[0] = 1'b1;
            end
            state_d = A_HI;
            case (in_byte)
                CMD_NOP: begin
                end
                CMD_CLR: begin
                    push     = 1'b1;
                    push_clr = 1'b1;
                end
                CMD_CLR_ERR: begin
                    // Also wipes an abort flagged by this very byte.
                    err_d = 3'b000;
                end
                default: begin
                    err_d[1] = 1'b1;
                end
            endcase
        end else if (data_acc) begin
            case (state_q)
                A_HI: state_d = A_LO;
                A_LO: state_d = B_HI;
                B_HI: state_d = B_LO;
                B_LO: begin
                    state_d = A_HI;
                    push    = 1'b1;
                    push_a  = a_q;
                    push_b  = join_bytes(first_q, in_byte);
                end
                default: state_d = A_HI;
            endcase
        end

`ifdef DLF_OPERAND_CHECK_EN
        if (push && is_denormal(push_a)) begin
            push_a   = 16'h0000;
            err_d[2] = 1'b1;
        end
        if (push && is_denormal(push_b)) begin
            push_b   = 16'h0000;
            err_d[2] = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= A_HI;
            first_q <= '0;
            a_q     <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (data_acc) begin
                if (state_q == A_HI || state_q == B_HI) begin
                    first_q <= in_byte;
                end
                if (state_q == A_LO) begin
                    a_q <= join_bytes(first_q, in_byte);
                end
            end
        end
    end

    // Storage is cleared on reset so the head outputs read zero while empty.
    // Pointers are AW bits wide, so they wrap at FIFO_DEPTH by overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {push_clr, push_a, push_b};
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_dlfloat_operand_loader.sv
// tb/tb_dlfloat_operand_loader.sv - self-checking bench for dlfloat_operand_loader

module tb_dlfloat_operand_loader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_cmd;
    logic        in_ready;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic        out_clr;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  err_status;
    logic [2:0]  fifo_count;

    int total = 0;
    int bad   = 0;
    logic [32:0] exp_q[$];

    dlfloat_operand_loader #(
        .FIFO_DEPTH(4),
        .MSB_FIRST (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_cmd    (in_cmd),
        .in_ready  (in_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_clr   (out_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_status(err_status),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_op(input logic [15:0] v);
`ifdef DLF_OPERAND_CHECK_EN
        if (v[14:9] == 6'd0 && v[8:0] != 9'd0) begin
            return 16'h0000;
        end
`endif
        return v;
    endfunction

    // Scoreboard consumer: every pop is compared with the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_pop observed=%h expected=none", {out_clr, out_a, out_b});
            end
            if (exp_q.size() != 0) begin
                check("pop_entry", {out_clr, out_a, out_b}, exp_q.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input logic cmd);
        int guard;
        guard    = 0;
        in_byte  = b;
        in_cmd   = cmd;
        in_valid = 1'b1;
        while (!in_ready && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("in_ready_timeout", {32'd0, in_ready}, 33'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_cmd   = 1'b0;
    endtask

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
        exp_q.push_back({1'b0, exp_op(a), exp_op(b)});
        send_byte(a[15:8], 1'b0);
        send_byte(a[7:0], 1'b0);
        send_byte(b[15:8], 1'b0);
        send_byte(b[7:0], 1'b0);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        if (c == 8'h01) begin
            exp_q.push_back(33'h1_0000_0000);
        end
        send_byte(c, 1'b1);
    endtask

    task automatic drain();
        int guard;
        guard     = 0;
        out_ready = 1'b1;
        while (out_valid && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        out_ready = 1'b0;
        check("drain_out_valid", {32'd0, out_valid}, 33'd0);
        check("drain_count", {30'd0, fifo_count}, 33'd0);
        check("scoreboard_empty", 33'(exp_q.size()), 33'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_byte   = 8'h00;
        in_valid  = 1'b0;
        in_cmd    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {32'd0, in_ready}, 33'd1);
        check("rst_out_valid", {32'd0, out_valid}, 33'd0);
        check("rst_head", {out_clr, out_a, out_b}, 33'd0);
        check("rst_err", {30'd0, err_status}, 33'd0);
        check("rst_count", {30'd0, fifo_count}, 33'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single pair, latency and same-cycle pop
        out_ready = 1'b1;
        send_pair(16'h3E00, 16'h4000);
        check("t1_valid", {32'd0, out_valid}, 33'd1);
        check("t1_head", {out_clr, out_a, out_b}, {1'b0, 16'h3E00, 16'h4000});
        @(posedge clk);
        #1;
        check("t1_count", {30'd0, fifo_count}, 33'd0);
        out_ready = 1'b0;

        // 2: fill, back-pressure, wrap, special values
        send_pair(16'h3E01, 16'hC200);
        send_pair(16'hFFFF, 16'h0000);
        send_pair(16'hBE00, 16'h8000);
        send_pair(16'h7FFF, 16'h1234);
        check("t2_full_ready", {32'd0, in_ready}, 33'd0);
        check("t2_full_count", {30'd0, fifo_count}, 33'd4);
        check("t2_head_hold", {out_clr, out_a, out_b}, {1'b0, 16'h3E01, 16'hC200});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("t2_after_pop_count", {30'd0, fifo_count}, 33'd3);
        check("t2_after_pop_ready", {32'd0, in_ready}, 33'd1);
        send_pair(16'h4200, 16'hA5A5);
        check("t2_refill_count", {30'd0, fifo_count}, 33'd4);
        drain();

        // 3: command mid-frame aborts, clr token, clean pair afterwards
        send_byte(8'h3E, 1'b0);
        send_byte(8'h00, 1'b0);
        send_cmd(8'h01);
        check("t3_err", {30'd0, err_status}, 33'd1);
        check("t3_clr_head", {out_valid, out_clr, out_a, out_b}, {2'b11, 32'd0});
        send_pair(16'h3F00, 16'h4100);
        check("t3_count", {30'd0, fifo_count}, 33'd2);
        drain();

        // 4: unknown command, then error clear
        send_cmd(8'h7F);
        check("t4_err_unknown", {30'd0, err_status}, 33'd3);
        check("t4_no_push", {30'd0, fifo_count}, 33'd0);
        send_cmd(8'h02);
        check("t4_err_cleared", {30'd0, err_status}, 33'd0);

        // 5: ordering of pair/clr/pair and head stability
        send_pair(16'h3E00, 16'hBE00);
        send_cmd(8'h01);
        send_pair(16'h0000, 16'hFFFF);
        check("t5_count", {30'd0, fifo_count}, 33'd3);
        for (int i = 0; i < 3; i++) begin
            check("t5_hold", {out_valid, out_clr, out_a, out_b}, {2'b10, 16'h3E00, 16'hBE00});
            @(posedge clk);
            #1;
        end
        check("t5_err", {30'd0, err_status}, 33'd0);
        drain();

        // 6: async reset mid-frame with entries queued
        send_pair(16'h3C00, 16'h3A00);
        send_pair(16'h4400, 16'h4600);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        check("t6_pre_count", {30'd0, fifo_count}, 33'd2);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", {32'd0, out_valid}, 33'd0);
        check("t6_rst_count", {30'd0, fifo_count}, 33'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_pair(16'h0005, 16'h3E00);
        check("t6_pair_head", {out_clr, out_a, out_b}, {1'b0, exp_op(16'h0005), 16'h3E00});
`ifdef DLF_OPERAND_CHECK_EN
        check("t6_err_denorm", {30'd0, err_status}, 33'd4);
`else
        check("t6_err_clean", {30'd0, err_status}, 33'd0);
`endif
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
